// File: rtl/status_flag_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : status_flag_ctrl
// Description : ZNCV status flag controller. Owns the committed flag
//               register, arbitrates stack restore / explicit write / masked
//               ALU update, keeps a LIFO save stack and evaluates branch
//               condition codes against the committed flags.
// Revision    : 1.0 - initial release
// ============================================================================
module status_flag_ctrl #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_alu_valid,
    input  logic [3:0] i_alu_flags,
    input  logic [3:0] i_alu_mask,
    input  logic       i_wr_valid,
    input  logic [3:0] i_wr_flags,
    input  logic       i_push,
    input  logic       i_pop,
    input  logic [3:0] i_cond,
    output logic [3:0] o_flags,
    output logic       o_cond_true,
    output logic       o_stack_empty,
    output logic       o_stack_full,
    output logic       o_drop,
    output logic       o_err
);

    localparam logic [PTR_W:0] c_FULL_COUNT = (PTR_W + 1)'(DEPTH);

    // Flag bit positions within {z,n,c,v}
    localparam int c_Z = 3;
    localparam int c_N = 2;
    localparam int c_C = 1;
    localparam int c_V = 0;

    logic [3:0]       r_flags;
    logic [PTR_W:0]   r_count;
    logic [3:0]       r_stack [DEPTH];
    logic             r_err;
    logic             r_drop;

    logic             w_empty;
    logic             w_full;
    logic             w_pop_ok;
    logic             w_push_ok;
    logic [PTR_W-1:0] w_top_idx;
    logic [PTR_W-1:0] w_wr_idx;
    logic [3:0]       w_flags_nxt;
    logic             w_drop_nxt;
    logic             w_err_nxt;
    logic [PTR_W:0]   w_count_nxt;
    logic             w_cond;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_FULL_COUNT);
    // Simultaneous push and pop cancel each other entirely
    assign w_pop_ok  = i_pop  & ~i_push & ~w_empty;
    assign w_push_ok = i_push & ~i_pop  & ~w_full;
    assign w_top_idx = PTR_W'(r_count - 1'b1);
    assign w_wr_idx  = PTR_W'(r_count);

    // Flag update arbitration: valid pop, then explicit write, then masked ALU
    always_comb begin
        w_flags_nxt = r_flags;
        w_drop_nxt  = 1'b0;
        if (w_pop_ok) begin
            w_flags_nxt = r_stack[w_top_idx];
            w_drop_nxt  = i_wr_valid | i_alu_valid;
        end else if (i_wr_valid) begin
            w_flags_nxt = i_wr_flags;
            w_drop_nxt  = i_alu_valid;
        end else if (i_alu_valid) begin
            w_flags_nxt = (r_flags & ~i_alu_mask) | (i_alu_flags & i_alu_mask);
        end
    end

    // Stack occupancy and sticky misuse error
    always_comb begin
        w_count_nxt = r_count;
        if (w_push_ok) begin
            w_count_nxt = r_count + 1'b1;
        end else if (w_pop_ok) begin
            w_count_nxt = r_count - 1'b1;
        end
        w_err_nxt = r_err
                  | (i_push & ~i_pop  & w_full)
                  | (i_pop  & ~i_push & w_empty);
    end

    // Committed state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags <= 4'b0000;
            r_count <= '0;
            r_err   <= 1'b0;
            r_drop  <= 1'b0;
        end else begin
            r_flags <= w_flags_nxt;
            r_count <= w_count_nxt;
            r_err   <= w_err_nxt;
            r_drop  <= w_drop_nxt;
        end
    end

    // Save stack storage; saves the flags as they were before this cycle's update
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_stack[w_wr_idx] <= r_flags;
        end
    end

    // Branch condition evaluation on committed flags (no forwarding)
    always_comb begin
        w_cond = 1'b0;
        case (i_cond)
            4'd0:    w_cond =  r_flags[c_Z];
            4'd1:    w_cond = ~r_flags[c_Z];
            4'd2:    w_cond =  r_flags[c_C];
            4'd3:    w_cond = ~r_flags[c_C];
            4'd4:    w_cond =  r_flags[c_N];
            4'd5:    w_cond = ~r_flags[c_N];
            4'd6:    w_cond =  r_flags[c_V];
            4'd7:    w_cond = ~r_flags[c_V];
            4'd8:    w_cond =  r_flags[c_C] & ~r_flags[c_Z];
            4'd9:    w_cond = ~r_flags[c_C] |  r_flags[c_Z];
            4'd10:   w_cond =  (r_flags[c_N] == r_flags[c_V]);
            4'd11:   w_cond =  (r_flags[c_N] != r_flags[c_V]);
            4'd12:   w_cond = ~r_flags[c_Z] &  (r_flags[c_N] == r_flags[c_V]);
            4'd13:   w_cond =  r_flags[c_Z] |  (r_flags[c_N] != r_flags[c_V]);
            4'd14:   w_cond = 1'b1;
            default: w_cond = 1'b0;
        endcase
    end

    assign o_flags       = r_flags;
    assign o_cond_true   = w_cond;
    assign o_stack_empty = w_empty;
    assign o_stack_full  = w_full;
    assign o_drop        = r_drop;
    assign o_err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_status_flag_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_status_flag_ctrl
// Description : Self-checking bench for status_flag_ctrl: directed scenarios
//               with literal expectations plus randomized traffic compared
//               every cycle against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_status_flag_ctrl;

    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       alu_valid = 1'b0;
    logic [3:0] alu_flags = 4'h0;
    logic [3:0] alu_mask = 4'h0;
    logic       wr_valid = 1'b0;
    logic [3:0] wr_flags = 4'h0;
    logic       push = 1'b0;
    logic       pop = 1'b0;
    logic [3:0] cond = 4'h0;
    logic [3:0] o_flags;
    logic       o_cond_true;
    logic       o_stack_empty;
    logic       o_stack_full;
    logic       o_drop;
    logic       o_err;

    status_flag_ctrl #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_alu_valid  (alu_valid),
        .i_alu_flags  (alu_flags),
        .i_alu_mask   (alu_mask),
        .i_wr_valid   (wr_valid),
        .i_wr_flags   (wr_flags),
        .i_push       (push),
        .i_pop        (pop),
        .i_cond       (cond),
        .o_flags      (o_flags),
        .o_cond_true  (o_cond_true),
        .o_stack_empty(o_stack_empty),
        .o_stack_full (o_stack_full),
        .o_drop       (o_drop),
        .o_err        (o_err)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [3:0] m_flags;
    logic [3:0] m_stack [$];
    bit         m_drop;
    bit         m_err;
    bit         chk_on = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Conditions come in complementary pairs; the odd code inverts the even one
    function automatic bit model_cond(input logic [3:0] c, input logic [3:0] f);
        bit z, n, cy, v, base;
        z = f[3]; n = f[2]; cy = f[1]; v = f[0];
        case (c >> 1)
            0: base = z;
            1: base = cy;
            2: base = n;
            3: base = v;
            4: base = cy && !z;
            5: base = (n == v);
            6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return base ^ c[0];
    endfunction

    task automatic model_reset();
        m_flags = 4'h0;
        m_stack.delete();
        m_drop = 1'b0;
        m_err = 1'b0;
    endtask

    // Advance one clock: evaluate model from current inputs, then commit after the edge
    task automatic tick();
        bit         is_empty, is_full, do_pop, do_push;
        logic [3:0] nf;
        bit         nd;
        is_empty = (m_stack.size() == 0);
        is_full  = (m_stack.size() == DEPTH);
        do_pop   = pop && !push && !is_empty;
        do_push  = push && !pop && !is_full;
        nf = m_flags;
        nd = 1'b0;
        if (do_pop) begin
            nf = m_stack[$];
            nd = wr_valid || alu_valid;
        end else if (wr_valid) begin
            nf = wr_flags;
            nd = alu_valid;
        end else if (alu_valid) begin
            for (int i = 0; i < 4; i++) if (alu_mask[i]) nf[i] = alu_flags[i];
        end
        @(posedge clk);
        if (do_pop)  void'(m_stack.pop_back());
        if (do_push) m_stack.push_back(m_flags);
        if ((push && !pop && is_full) || (pop && !push && is_empty)) m_err = 1'b1;
        m_flags = nf;
        m_drop  = nd;
        #1;
    endtask

    task automatic idle();
        alu_valid = 0; wr_valid = 0; push = 0; pop = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        model_reset();
        #1;
        check("rst_flags", {4'h0, o_flags}, 8'h00);
        check("rst_empty", {7'h0, o_stack_empty}, 8'h01);
        check("rst_err",   {7'h0, o_err}, 8'h00);
        check("rst_drop",  {7'h0, o_drop}, 8'h00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (chk_on) begin
            check("flags",     {4'h0, o_flags}, {4'h0, m_flags});
            check("cond_true", {7'h0, o_cond_true}, {7'h0, model_cond(cond, m_flags)});
            check("empty",     {7'h0, o_stack_empty}, {7'h0, m_stack.size() == 0});
            check("full",      {7'h0, o_stack_full}, {7'h0, m_stack.size() == DEPTH});
            check("drop",      {7'h0, o_drop}, {7'h0, m_drop});
            check("err",       {7'h0, o_err}, {7'h0, m_err});
        end
    end

    initial begin
        model_reset();
        chk_on = 1'b1;
        do_reset();

        // Reset condition codes
        cond = 4'd0;  #1; check("eq_rst", {7'h0, o_cond_true}, 8'h00);
        cond = 4'd14; #1; check("al_rst", {7'h0, o_cond_true}, 8'h01);
        cond = 4'd15; #1; check("nv_rst", {7'h0, o_cond_true}, 8'h00);
        check("full_rst", {7'h0, o_stack_full}, 8'h00);

        // Masked ALU update
        alu_valid = 1; alu_flags = 4'b1111; alu_mask = 4'b1010;
        tick(); idle();
        check("alu_mask", {4'h0, o_flags}, 8'h0A);
        cond = 4'd12; #1; check("gt", {7'h0, o_cond_true}, 8'h00);
        cond = 4'd10; #1; check("ge", {7'h0, o_cond_true}, 8'h01);

        // Push saves pre-update flags while the ALU update still applies
        wr_valid = 1; wr_flags = 4'b0110; tick(); idle();
        push = 1; alu_valid = 1; alu_flags = 4'b1001; alu_mask = 4'b1111;
        tick(); idle();
        check("push_alu_flags", {4'h0, o_flags}, 8'h09);
        check("push_alu_empty", {7'h0, o_stack_empty}, 8'h00);
        pop = 1; tick(); idle();
        check("pop_restore", {4'h0, o_flags}, 8'h06);
        check("pop_empty", {7'h0, o_stack_empty}, 8'h01);

        // Write beats ALU; drop pulses for exactly one cycle
        wr_valid = 1; wr_flags = 4'b0001; alu_valid = 1; alu_flags = 4'b1000;
        tick(); idle();
        check("wr_win", {4'h0, o_flags}, 8'h01);
        check("drop_wr_alu", {7'h0, o_drop}, 8'h01);
        tick();
        check("drop_clear", {7'h0, o_drop}, 8'h00);

        // Pop beats write
        push = 1; tick(); idle();
        wr_valid = 1; wr_flags = 4'b0111; tick(); idle();
        pop = 1; wr_valid = 1; wr_flags = 4'b1100; tick(); idle();
        check("pop_win", {4'h0, o_flags}, 8'h01);
        check("drop_pop_wr", {7'h0, o_drop}, 8'h01);
        check("err_clean", {7'h0, o_err}, 8'h00);

        // Pop on empty: error, flags unchanged, write in same cycle still lands
        pop = 1; tick(); idle();
        check("pop_empty_err", {7'h0, o_err}, 8'h01);
        check("pop_empty_flags", {4'h0, o_flags}, 8'h01);
        pop = 1; wr_valid = 1; wr_flags = 4'b0011; tick(); idle();
        check("pop_empty_wr", {4'h0, o_flags}, 8'h03);
        check("pop_empty_nodrop", {7'h0, o_drop}, 8'h00);

        // Overflow and LIFO order
        do_reset();
        wr_valid = 1; wr_flags = 4'h1; tick(); idle();
        for (int i = 0; i <= DEPTH; i++) begin
            push = 1; wr_valid = 1; wr_flags = 4'(i + 2);
            tick(); idle();
            if (i == DEPTH - 1) begin
                check("full_at_depth", {7'h0, o_stack_full}, 8'h01);
                check("no_err_at_depth", {7'h0, o_err}, 8'h00);
            end
        end
        check("overflow_err", {7'h0, o_err}, 8'h01);
        check("overflow_full", {7'h0, o_stack_full}, 8'h01);
        for (int i = 0; i < DEPTH; i++) begin
            pop = 1; tick(); idle();
            check("lifo", {4'h0, o_flags}, 8'(DEPTH - i));
        end
        check("lifo_empty", {7'h0, o_stack_empty}, 8'h01);

        // Reset mid-operation with two entries
        push = 1; tick(); tick(); idle();
        check("two_entries", {7'h0, o_stack_empty}, 8'h00);
        do_reset();
        pop = 1; tick(); idle();
        check("post_reset_pop_err", {7'h0, o_err}, 8'h01);

        // Randomized traffic
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            pop       = ($urandom_range(0, 99) < 30);
            push      = ($urandom_range(0, 99) < 30);
            wr_valid  = ($urandom_range(0, 99) < 30);
            alu_valid = ($urandom_range(0, 99) < 50);
            wr_flags  = 4'($urandom);
            alu_flags = 4'($urandom);
            alu_mask  = 4'($urandom);
            cond      = 4'($urandom);
            tick();
            if (n % 700 == 699) do_reset();
        end
        idle();
        tick();
        chk_on = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/status_flag_ctrl.md
# status_flag_ctrl

Controller for the processor's ZNCV status flags, sitting between the ALU, the instruction decoder and the branch unit. It owns the committed flag register and decides each cycle which source may update it: a restore from a save stack, an explicit flag write, or an ALU result with a per-flag update mask. It also keeps a small LIFO save stack for call/interrupt entry and exit, and evaluates a 4-bit branch condition code against the committed flags.

## Interface
- DEPTH, 4, number of save-stack entries (power of two, >= 2)
- PTR_W, 2, log2(DEPTH)
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- alu_valid  in  1  ALU result available this cycle
- alu_flags  in  4  ALU flags {z,n,c,v}
- alu_mask  in  4  per-flag update enable for the ALU op, same bit order
- wr_valid  in  1  explicit flag write (flag-move instruction)
- wr_flags  in  4  value for explicit write {z,n,c,v}
- push  in  1  save committed flags onto stack
- pop  in  1  restore flags from stack top
- cond  in  4  branch condition code
- flags  out  4  committed flags {z,n,c,v}, registered
- cond_true  out  1  cond evaluated on committed flags, combinational from flags and cond
- stack_empty  out  1  stack holds 0 entries
- stack_full  out  1  stack holds DEPTH entries
- drop  out  1  registered one-cycle pulse: an update request was discarded by priority
- err  out  1  sticky: push when full or pop when empty

## Operation
- State: flags register, DEPTH x 4 stack array, count register (PTR_W+1 bits, 0..DEPTH), err, drop.
- Update priority each cycle: valid pop > wr_valid > alu_valid. Only the winner changes flags.
- Pop (stack not empty, push low): flags <= stack[count-1]; count decrements.
- wr_valid winner: flags <= wr_flags (all four bits).
- alu_valid winner: per bit i, flags[i] <= alu_mask[i] ? alu_flags[i] : flags[i]. alu_mask = 0 is a legal no-op.
- drop asserted next cycle when a lower-priority request (wr_valid or alu_valid) lost to a higher one in this cycle; otherwise drop is 0.
- Push (stack not full, pop low): stack[count] <= flags value before this cycle's update; count increments. A flag update in the same cycle still applies.
- push and pop in the same cycle: both ignored; stack and count unchanged, err unchanged; wr_valid/alu_valid are then arbitrated normally.
- Push when full: ignored, err <= 1. Pop when empty: ignored, err <= 1; it does not block wr_valid/alu_valid that cycle.
- err clears only on reset.
- stack_empty = (count == 0), stack_full = (count == DEPTH), both from registered count.
- Condition codes: 0 EQ z; 1 NE !z; 2 CS c; 3 CC !c; 4 MI n; 5 PL !n; 6 VS v; 7 VC !v; 8 HI c&!z; 9 LS !c|z; 10 GE n==v; 11 LT n!=v; 12 GT !z&(n==v); 13 LE z|(n!=v); 14 AL 1; 15 NV 0.

## Timing
- Reset (async assert, sync release by system): flags=0000, count=0, stack_empty=1, stack_full=0, drop=0, err=0; stack contents undefined and never observable.
- flags, count and status outputs change one cycle after the request edge (latency 1).
- cond_true reflects committed flags: a branch in the cycle after an ALU update sees the new value; in the same cycle it sees the old value (no forwarding).
- Reset mid-operation discards stack contents and any in-flight request; first post-reset pop reports err.
- Sustained push/pop every cycle supported; no busy state, no back-pressure.

## Test plan
- Reset then cond=0 (EQ) -> flags=0000, cond_true=0; cond=14 -> 1; cond=15 -> 0; stack_empty=1, err=0.
- alu_valid, alu_flags=1111, alu_mask=1010 -> next cycle flags=1010; then cond=12 (GT) -> 0, cond=10 (GE) -> 1.
- flags=0110, push + alu_valid(1001, mask 1111) same cycle -> flags=1001, count=1; pop -> flags=0110, stack_empty=1.
- wr_valid(0001) and alu_valid(1000, mask 1111) same cycle -> flags=0001, drop=1 for one cycle; pop+wr_valid with stack non-empty -> restored value wins, drop=1.
- Push DEPTH+1 times -> stack_full=1 after DEPTH, extra push sets err=1, count stays DEPTH; pop DEPTH times returns values in LIFO order.
- Pop on empty -> err=1, flags unchanged; assert rst_n low mid-sequence with 2 entries -> count=0, err=0, flags=0000 immediately.
